// File: rtl/axis_parity_pkg.sv
// Shared types and constants for the AXI-Stream parity responder.
// Response FSM states, response words and the error-word helper.
package axis_parity_pkg;

    typedef enum logic [2:0] {
        RECV,
        RESP_HDR,
        RESP_CNT,
        RESP_TRL,
        RESP_ERR
    } resp_state_t;

    localparam logic [7:0] OK_HDR = 8'hAB;
    localparam logic [7:0] OK_TRL = 8'hDE;

    // Widest stream the error-word helper can describe.
    localparam int MAX_W = 256;

    // All-ones word of the requested width, zero above it.
    function automatic logic [MAX_W-1:0] err_word(input int width);
        logic [MAX_W-1:0] w;
        w = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                w[i] = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/axis_parity_accum.sv
// Running parity and saturating beat count for one inbound packet.
// Final values include the current beat; state clears on the last beat.
module axis_parity_accum
    import axis_parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat,
    input  logic              last,
    input  logic [DATA_W-1:0] data,
    output logic              parity_final,
    output logic [CNT_W-1:0]  count_final
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             acc_q;
    logic             acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Fold the current beat into parity/count; clear once the packet ends.
    always_comb begin
        cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        parity_final = acc_q ^ (^data);
        count_final  = cnt_inc;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        if (beat) begin
            if (last) begin
                acc_d = 1'b0;
                cnt_d = '0;
            end else begin
                acc_d = parity_final;
                cnt_d = cnt_inc;
            end
        end
    end

    // Accumulator state; reset discards any partial packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_parity_responder.sv
// AXI-Stream packet parity checker that answers each packet with
// an OK header/count/trailer response or a single error word.
module axis_parity_responder
    import axis_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              a_clk,
    input  logic              axis_areset,
    input  logic              axis_s_tvalid,
    input  logic [DATA_W-1:0] axis_s_tdata,
    output logic              axis_s_tready,
    input  logic              axis_s_tlast,
    output logic              axis_m_tvalid,
    output logic [DATA_W-1:0] axis_m_tdata,
    input  logic              axis_m_tready,
    output logic              axis_m_tlast,
    output logic              parity_err
);

    localparam logic              ODD      = (PARITY_ODD != 0);
    localparam logic [DATA_W-1:0] HDR_WORD = DATA_W'(OK_HDR);
    localparam logic [DATA_W-1:0] TRL_WORD = DATA_W'(OK_TRL);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(err_word(DATA_W));

    resp_state_t       state_q;
    logic              s_tready_q;
    logic              m_tvalid_q;
    logic [DATA_W-1:0] m_tdata_q;
    logic              m_tlast_q;
    logic              perr_q;
    logic [CNT_W-1:0]  cnt_lat_q;

    logic              accept;
    logic              m_fire;
    logic              parity_final;
    logic [CNT_W-1:0]  count_final;

    assign accept = axis_s_tvalid & s_tready_q;
    assign m_fire = m_tvalid_q & axis_m_tready;

    axis_parity_accum #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_accum (
        .clk          (a_clk),
        .rst          (axis_areset),
        .beat         (accept),
        .last         (axis_s_tlast),
        .data         (axis_s_tdata),
        .parity_final (parity_final),
        .count_final  (count_final)
    );

    // Receive/respond FSM with every output driven from a register.
    always_ff @(posedge a_clk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q    <= RECV;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            perr_q     <= 1'b0;
            cnt_lat_q  <= '0;
        end else begin
            perr_q <= 1'b0;
            unique case (state_q)
                RECV: begin
                    if (accept && axis_s_tlast) begin
                        s_tready_q <= 1'b0;
                        m_tvalid_q <= 1'b1;
                        if (parity_final != ODD) begin
                            state_q   <= RESP_ERR;
                            m_tdata_q <= ERR_WORD;
                            m_tlast_q <= 1'b1;
                            perr_q    <= 1'b1;
                        end else begin
                            state_q   <= RESP_HDR;
                            m_tdata_q <= HDR_WORD;
                            m_tlast_q <= 1'b0;
                            cnt_lat_q <= count_final;
                        end
                    end else begin
                        s_tready_q <= 1'b1;
                    end
                end
                RESP_HDR: begin
                    if (m_fire) begin
                        state_q   <= RESP_CNT;
                        m_tdata_q <= DATA_W'(cnt_lat_q);
                    end
                end
                RESP_CNT: begin
                    if (m_fire) begin
                        state_q   <= RESP_TRL;
                        m_tdata_q <= TRL_WORD;
                        m_tlast_q <= 1'b1;
                    end
                end
                RESP_TRL, RESP_ERR: begin
                    if (m_fire) begin
                        state_q    <= RECV;
                        s_tready_q <= 1'b1;
                        m_tvalid_q <= 1'b0;
                        m_tdata_q  <= '0;
                        m_tlast_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RECV;
                    s_tready_q <= 1'b0;
                    m_tvalid_q <= 1'b0;
                    m_tdata_q  <= '0;
                    m_tlast_q  <= 1'b0;
                end
            endcase
        end
    end

    assign axis_s_tready = s_tready_q;
    assign axis_m_tvalid = m_tvalid_q;
    assign axis_m_tdata  = m_tdata_q;
    assign axis_m_tlast  = m_tlast_q;
    assign parity_err    = perr_q;

endmodule

// File: tb/tb_axis_parity_responder.sv
// Self-checking bench for axis_parity_responder over four configurations.
// Table vectors, hand-written corner sequences and a random packet model.
module tb_axis_parity_responder;

    // Instance k: 0 = 8b even, 1 = 8b odd, 2 = 8b even CNT_W=4, 3 = 32b even
    logic        a_clk = 1'b0;
    logic        axis_areset;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tvalid [4];
    logic        m_tready [4];
    logic        sr [4];
    logic        mv [4];
    logic        ml [4];
    logic        pe [4];
    logic [7:0]  md0, md1, md2;
    logic [31:0] md3;
    logic [31:0] m_tdata [4];

    assign m_tdata[0] = {24'h0, md0};
    assign m_tdata[1] = {24'h0, md1};
    assign m_tdata[2] = {24'h0, md2};
    assign m_tdata[3] = md3;

    always #5 a_clk = ~a_clk;

    axis_parity_responder #(.DATA_W(8), .CNT_W(8), .PARITY_ODD(0)) u0 (
        .a_clk(a_clk), .axis_areset(axis_areset),
        .axis_s_tvalid(s_tvalid[0]), .axis_s_tdata(s_tdata[7:0]),
        .axis_s_tready(sr[0]), .axis_s_tlast(s_tlast),
        .axis_m_tvalid(mv[0]), .axis_m_tdata(md0),
        .axis_m_tready(m_tready[0]), .axis_m_tlast(ml[0]),
        .parity_err(pe[0]));

    axis_parity_responder #(.DATA_W(8), .CNT_W(8), .PARITY_ODD(1)) u1 (
        .a_clk(a_clk), .axis_areset(axis_areset),
        .axis_s_tvalid(s_tvalid[1]), .axis_s_tdata(s_tdata[7:0]),
        .axis_s_tready(sr[1]), .axis_s_tlast(s_tlast),
        .axis_m_tvalid(mv[1]), .axis_m_tdata(md1),
        .axis_m_tready(m_tready[1]), .axis_m_tlast(ml[1]),
        .parity_err(pe[1]));

    axis_parity_responder #(.DATA_W(8), .CNT_W(4), .PARITY_ODD(0)) u2 (
        .a_clk(a_clk), .axis_areset(axis_areset),
        .axis_s_tvalid(s_tvalid[2]), .axis_s_tdata(s_tdata[7:0]),
        .axis_s_tready(sr[2]), .axis_s_tlast(s_tlast),
        .axis_m_tvalid(mv[2]), .axis_m_tdata(md2),
        .axis_m_tready(m_tready[2]), .axis_m_tlast(ml[2]),
        .parity_err(pe[2]));

    axis_parity_responder #(.DATA_W(32), .CNT_W(8), .PARITY_ODD(0)) u3 (
        .a_clk(a_clk), .axis_areset(axis_areset),
        .axis_s_tvalid(s_tvalid[3]), .axis_s_tdata(s_tdata),
        .axis_s_tready(sr[3]), .axis_s_tlast(s_tlast),
        .axis_m_tvalid(mv[3]), .axis_m_tdata(md3),
        .axis_m_tready(m_tready[3]), .axis_m_tlast(ml[3]),
        .parity_err(pe[3]));

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] pkt_q [$];
    logic [31:0] exp_q [$];
    logic        exp_err;

    typedef struct {
        int          k;
        int          n;
        logic [31:0] d [4];
        logic        err;
        int          nr;
        logic [31:0] r [3];
    } vec_t;

    vec_t tbl [7];

    function automatic int dw(int k);
        return (k == 3) ? 32 : 8;
    endfunction

    function automatic int cw(int k);
        return (k == 2) ? 4 : 8;
    endfunction

    function automatic int po(int k);
        return (k == 1) ? 1 : 0;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: expected response straight from the packet contents.
    task automatic model(int k);
        int ones;
        int n;
        int maxc;
        ones = 0;
        foreach (pkt_q[i]) ones += $countones(pkt_q[i]);
        n    = pkt_q.size();
        maxc = (1 << cw(k)) - 1;
        exp_q.delete();
        exp_err = ((ones % 2) != po(k));
        if (exp_err) begin
            exp_q.push_back((dw(k) == 32) ? 32'hFFFF_FFFF : 32'hFF);
        end else begin
            exp_q.push_back(32'hAB);
            exp_q.push_back(32'((n < maxc) ? n : maxc));
            exp_q.push_back(32'hDE);
        end
    endtask

    task automatic set_vec(int idx, int k, int n, logic [31:0] d0,
                           logic [31:0] d1, logic [31:0] d2,
                           logic [31:0] d3, logic err, int nr,
                           logic [31:0] r0, logic [31:0] r1,
                           logic [31:0] r2);
        tbl[idx].k    = k;
        tbl[idx].n    = n;
        tbl[idx].d[0] = d0;
        tbl[idx].d[1] = d1;
        tbl[idx].d[2] = d2;
        tbl[idx].d[3] = d3;
        tbl[idx].err  = err;
        tbl[idx].nr   = nr;
        tbl[idx].r[0] = r0;
        tbl[idx].r[1] = r1;
        tbl[idx].r[2] = r2;
    endtask

    // Drive pkt_q into instance k; called and returns at a negedge.
    task automatic send(int k, bit with_last, int idle_pct);
        int t;
        for (int i = 0; i < pkt_q.size(); i++) begin
            while ($urandom_range(99) < idle_pct) @(negedge a_clk);
            s_tvalid[k] = 1'b1;
            s_tdata     = pkt_q[i];
            s_tlast     = with_last && (i == pkt_q.size() - 1);
            t = 0;
            while (!sr[k] && t < 50) begin
                @(negedge a_clk);
                t++;
            end
            if (t >= 50) check("s_tready_timeout", 32'(sr[k]), 32'd1);
            @(posedge a_clk);
            #1;
            if (s_tlast) begin
                check("parity_err_pulse", 32'(pe[k]), 32'(exp_err));
                check("m_tvalid_latency", 32'(mv[k]), 32'd1);
                check("s_tready_drop", 32'(sr[k]), 32'd0);
            end
            @(negedge a_clk);
            s_tvalid[k] = 1'b0;
            s_tlast     = 1'b0;
        end
    endtask

    // Drain exp_q from instance k with random or forced backpressure.
    task automatic collect(int k, int rdy_pct, int stall_idx, int stall_n);
        int          i;
        int          t;
        int          stalled;
        bit          r;
        bit          held;
        logic [31:0] hd;
        logic        hl;
        i = 0;
        t = 0;
        stalled = 0;
        held = 0;
        while (i < exp_q.size() && t < 500) begin
            r = ($urandom_range(99) < rdy_pct);
            if (i == stall_idx && stalled < stall_n) begin
                r = 1'b0;
                stalled++;
            end
            m_tready[k] = r;
            check("s_tready_in_resp", 32'(sr[k]), 32'd0);
            check("m_tvalid_in_resp", 32'(mv[k]), 32'd1);
            if (held) begin
                check("stall_data_hold", m_tdata[k], hd);
                check("stall_last_hold", 32'(ml[k]), 32'(hl));
            end
            if (mv[k] && r) begin
                check("resp_data", m_tdata[k], exp_q[i]);
                check("resp_last", 32'(ml[k]),
                      32'(i == exp_q.size() - 1));
                i++;
                held = 0;
            end else begin
                held = 1;
                hd   = m_tdata[k];
                hl   = ml[k];
            end
            @(posedge a_clk);
            @(negedge a_clk);
            t++;
        end
        if (t >= 500) check("resp_timeout", 32'(i), 32'(exp_q.size()));
        m_tready[k] = 1'b1;
        check("s_tready_after", 32'(sr[k]), 32'd1);
        check("m_tvalid_after", 32'(mv[k]), 32'd0);
        check("parity_err_after", 32'(pe[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int n;
        axis_areset = 1'b1;
        s_tdata = '0;
        s_tlast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i] = 1'b0;
            m_tready[i] = 1'b1;
        end

        set_vec(0, 0, 3, 32'h03, 32'h05, 32'h0F, 0, 1'b0, 3,
                32'hAB, 32'h03, 32'hDE);
        set_vec(1, 0, 1, 32'h01, 0, 0, 0, 1'b1, 1, 32'hFF, 0, 0);
        set_vec(2, 1, 2, 32'h01, 32'h00, 0, 0, 1'b0, 3,
                32'hAB, 32'h02, 32'hDE);
        set_vec(3, 1, 1, 32'h00, 0, 0, 0, 1'b1, 1, 32'hFF, 0, 0);
        set_vec(4, 0, 2, 32'hFF, 32'hFF, 0, 0, 1'b0, 3,
                32'hAB, 32'h02, 32'hDE);
        set_vec(5, 3, 1, 32'h8000_0000, 0, 0, 0, 1'b1, 1,
                32'hFFFF_FFFF, 0, 0);
        set_vec(6, 2, 4, 32'h11, 32'h22, 32'h44, 32'h81, 1'b0, 3,
                32'hAB, 32'h04, 32'hDE);

        repeat (3) @(posedge a_clk);
        @(negedge a_clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_s_tready", 32'(sr[i]), 32'd0);
            check("rst_m_tvalid", 32'(mv[i]), 32'd0);
            check("rst_m_tdata", m_tdata[i], 32'd0);
            check("rst_m_tlast", 32'(ml[i]), 32'd0);
            check("rst_parity_err", 32'(pe[i]), 32'd0);
        end
        axis_areset = 1'b0;
        @(negedge a_clk);
        for (int i = 0; i < 4; i++) begin
            check("s_tready_rise", 32'(sr[i]), 32'd1);
        end

        for (int v = 0; v < 7; v++) begin
            pkt_q.delete();
            exp_q.delete();
            for (int j = 0; j < tbl[v].n; j++) pkt_q.push_back(tbl[v].d[j]);
            for (int j = 0; j < tbl[v].nr; j++) exp_q.push_back(tbl[v].r[j]);
            exp_err = tbl[v].err;
            send(tbl[v].k, 1'b1, 0);
            collect(tbl[v].k, 100, -1, 0);
        end

        // Backpressure: hold off the count beat for 5 cycles.
        pkt_q = '{32'h03, 32'h05, 32'h0F};
        exp_q = '{32'hAB, 32'h03, 32'hDE};
        exp_err = 1'b0;
        send(0, 1'b1, 0);
        collect(0, 100, 1, 5);

        // Saturation: 20 even-parity beats into a 4-bit counter.
        pkt_q.delete();
        for (int j = 0; j < 20; j++) pkt_q.push_back(32'h03);
        exp_q = '{32'hAB, 32'h0F, 32'hDE};
        exp_err = 1'b0;
        send(2, 1'b1, 0);
        collect(2, 100, -1, 0);

        // Reset mid-packet on the 32-bit instance.
        pkt_q = '{32'h0000_0001, 32'h0000_0000};
        send(3, 1'b0, 0);
        s_tvalid[3] = 1'b1;
        s_tdata     = 32'h0000_0003;
        axis_areset = 1'b1;
        #1;
        check("rst_mid_pkt_s_tready", 32'(sr[3]), 32'd0);
        check("rst_mid_pkt_m_tvalid", 32'(mv[3]), 32'd0);
        @(negedge a_clk);
        s_tvalid[3] = 1'b0;
        @(negedge a_clk);
        axis_areset = 1'b0;
        @(negedge a_clk);
        check("rst_release_s_tready", 32'(sr[3]), 32'd1);
        check("rst_release_m_tvalid", 32'(mv[3]), 32'd0);
        pkt_q = '{32'h0000_0001, 32'h0000_0001};
        exp_q = '{32'h0000_00AB, 32'h0000_0002, 32'h0000_00DE};
        exp_err = 1'b0;
        send(3, 1'b1, 0);
        collect(3, 100, -1, 0);

        // Reset mid-response on instance 0 after the header beat.
        pkt_q = '{32'h03, 32'h05, 32'h0F};
        exp_err = 1'b0;
        send(0, 1'b1, 0);
        @(posedge a_clk);
        @(negedge a_clk);
        check("pre_rst_cnt_beat", m_tdata[0], 32'h03);
        axis_areset = 1'b1;
        #1;
        check("rst_mid_resp_m_tvalid", 32'(mv[0]), 32'd0);
        check("rst_mid_resp_s_tready", 32'(sr[0]), 32'd0);
        @(negedge a_clk);
        axis_areset = 1'b0;
        @(negedge a_clk);
        check("rst_resp_release_s_tready", 32'(sr[0]), 32'd1);
        check("rst_resp_release_m_tvalid", 32'(mv[0]), 32'd0);

        // Random packets against the reference model.
        for (int p = 0; p < 60; p++) begin
            k = int'($urandom_range(3));
            n = int'($urandom_range(1, 20));
            pkt_q.delete();
            for (int j = 0; j < n; j++) begin
                pkt_q.push_back((k == 3) ? $urandom : ($urandom & 32'hFF));
            end
            model(k);
            send(k, 1'b1, 30);
            collect(k, 60, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_parity_responder.md
# axis_parity_responder

Parametrised AXI-Stream packet parity checker that replies with a response packet. It accepts packets on a slave AXI-Stream port and accumulates bitwise parity and a beat count until `tlast`. It then emits a response packet on the master port: a multi-beat OK response carrying the beat count, or a single-beat error word. It sits between a packet source and a host-side consumer as the successor of the fixed 8-bit parity tester, adding width, parity mode, byte count and full backpressure support.

## Interface
- `DATA_W`, 8: stream data width in bits; must be a multiple of 8.
- `CNT_W`, 8: beat-counter width; must be ≤ `DATA_W`.
- `PARITY_ODD`, 0: 0 selects even parity (packet XOR must be 0); 1 selects odd parity (packet XOR must be 1).
- `a_clk`, in, 1: the block's single clock.
- `axis_areset`, in, 1: reset, asynchronous and active-high.
- `axis_s_tvalid`, in, 1: slave beat valid.
- `axis_s_tdata`, in, `DATA_W`: slave beat data.
- `axis_s_tready`, out, 1: slave ready.
- `axis_s_tlast`, in, 1: last beat of the slave packet.
- `axis_m_tvalid`, out, 1: response beat valid.
- `axis_m_tdata`, out, `DATA_W`: response beat data.
- `axis_m_tready`, in, 1: downstream ready.
- `axis_m_tlast`, out, 1: last beat of the response packet.
- `parity_err`, out, 1: one-cycle pulse when a packet fails the parity check.

## Operation
- States: `RECV`, `RESP_HDR`, `RESP_CNT`, `RESP_TRL`, `RESP_ERR`.
- `RECV`:
  - `axis_s_tready` = 1.
  - Each accepted beat (`tvalid & tready`) updates the parity accumulator: `acc ^= ^tdata`.
  - The beat counter increments and saturates at 2^`CNT_W`−1.
- Accepted beat with `tlast`:
  - Final parity is `acc ^ (^tdata)`; the final count includes this beat.
  - Error when final parity ≠ `PARITY_ODD`.
  - On error: go to `RESP_ERR` and pulse `parity_err`. Otherwise go to `RESP_HDR`.
  - Accumulator and counter clear in the same edge.
- `RESP_HDR`: drive `OK_HDR` (0xAB, zero-extended to `DATA_W`) with `tlast` = 0.
- `RESP_CNT`: drive the latched count, zero-extended, with `tlast` = 0.
- `RESP_TRL`: drive `OK_TRL` (0xDE, zero-extended) with `tlast` = 1.
- `RESP_ERR`: drive `ERR_WORD` (all ones, `DATA_W` bits) with `tlast` = 1.
- Each response state advances only on `axis_m_tvalid & axis_m_tready`. Once valid, `axis_m_tdata` and `axis_m_tlast` hold stable until the handshake completes.
- After the handshake of the final response beat, the FSM returns to `RECV`.
- `axis_s_tready` = 0 in all response states. No slave beats are accepted or lost during a response.
- Zero-length packets cannot occur: a packet has at least the `tlast` beat.

## Timing
- Reset values:
  - `axis_s_tready` = 0 while reset is asserted; it rises in `RECV` on the first edge after deassertion.
  - `axis_m_tvalid` = 0, `axis_m_tdata` = 0, `axis_m_tlast` = 0, `parity_err` = 0.
  - State = `RECV`; accumulator and counter = 0.
- Latency: `tlast` accepted at edge N → `axis_m_tvalid` = 1 with the first response beat after edge N. `parity_err` is high for the cycle after edge N.
- OK response, `axis_m_tready` held high: 3 consecutive beats, then `axis_s_tready` = 1 in the following cycle.
- Error response, `axis_m_tready` held high: 1 beat, then `axis_s_tready` = 1 in the following cycle.
- All outputs are registered; there is no combinational path from slave inputs to master outputs.
- `axis_m_tready` low stalls the FSM indefinitely with outputs held.
- Reset asserted mid-packet or mid-response:
  - Immediately drops `axis_m_tvalid` and `axis_s_tready`.
  - Discards the partial accumulation; no response is emitted for that packet.
- Counter saturation: count stays at 2^`CNT_W`−1 and does not wrap.

## Structure
- Shared package `axis_parity_pkg`:
  - State enum `resp_state_t`.
  - Constants `OK_HDR` = 8'hAB, `OK_TRL` = 8'hDE.
  - Function `err_word(width)` returning all ones.
- One sub-module, `axis_parity_accum`:
  - Holds the parity accumulator and the saturating beat counter.
  - Inputs: `beat`, `last`, `data`. Outputs: `parity_final`, `count_final`.
  - Clears on `last`.
- The top level holds the FSM and the master output registers.

## Test plan
- Even mode, `DATA_W`=8, packet {0x03, 0x05, 0x0F(last)} (XOR parity 0) → response 0xAB, 0x03, 0xDE(last); `parity_err` = 0.
- Even mode, packet {0x01(last)} → single beat 0xFF(last); `parity_err` pulses once, for one cycle after the accepting edge.
- Odd mode, packet {0x01, 0x00(last)} → 0xAB, 0x02, 0xDE(last).
- Backpressure: `axis_m_tready` low for 5 cycles during `RESP_CNT` → 0x03 held stable; `axis_s_tready` = 0 throughout; completes after tready rises.
- `CNT_W`=4, 20-beat even-parity packet → count beat = 0x0F (saturated).
- `DATA_W`=32, reset asserted after 2 of 4 beats, then a fresh packet {0x00000001, 0x00000001(last)} → no response for the aborted packet; 0x000000AB, 0x00000002, 0x000000DE(last) for the fresh one.
